// File: rtl/fetch_imem_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   req    : request strobe, one cycle per fetch
//   addr   : word-aligned request address
//   rvalid : read data valid, arrives at least one cycle after req
//   rdata  : instruction word
// master is the fetch side, slave is the memory side.
interface fetch_imem_if #(
  parameter int unsigned NB = 32
) ();
  logic          req;
  logic [NB-1:0] addr;
  logic          rvalid;
  logic [NB-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the RV32I core.
// Holds the architectural PC, issues at most one outstanding instruction-memory
// request and fills the IF/ID register. A one-entry skid buffer keeps a returned
// instruction while decode is stalled. A redirect flushes stale fetches.
// Ports:
//   clk, rst_n    : core clock, asynchronous active-low reset
//   next_pc_i     : next-PC mux output (pc_o+4, branch or jump target)
//   redirect_i    : taken branch/jump, next_pc_i holds the target
//   stall_i       : decode stalled, hold the IF/ID register
//   pc_o          : current fetch PC
//   imem          : instruction-memory bus (master side)
//   if_valid_o    : IF/ID register holds a valid instruction
//   if_pc_o       : PC of the IF/ID instruction
//   if_instr_o    : IF/ID instruction word
module fetch_unit #(
  parameter int unsigned   NB       = 32,
  parameter logic [NB-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NB-1:0] next_pc_i,
  input  logic          redirect_i,
  input  logic          stall_i,
  output logic [NB-1:0] pc_o,
  fetch_imem_if.master  imem,
  output logic          if_valid_o,
  output logic [NB-1:0] if_pc_o,
  output logic [NB-1:0] if_instr_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e        r_state,      w_state_d;
  logic [NB-1:0] r_pc,         w_pc_d;
  logic          r_drop,       w_drop_d;
  logic [NB-1:0] r_skid_pc,    w_skid_pc_d;
  logic [NB-1:0] r_skid_instr, w_skid_instr_d;
  logic          r_if_valid,   w_if_valid_d;
  logic [NB-1:0] r_if_pc,      w_if_pc_d;
  logic [NB-1:0] r_if_instr,   w_if_instr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_instr   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_drop       <= w_drop_d;
      r_skid_pc    <= w_skid_pc_d;
      r_skid_instr <= w_skid_instr_d;
      r_if_valid   <= w_if_valid_d;
      r_if_pc      <= w_if_pc_d;
      r_if_instr   <= w_if_instr_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_drop_d       = r_drop;
    w_skid_pc_d    = r_skid_pc;
    w_skid_instr_d = r_skid_instr;
    w_if_valid_d   = r_if_valid;
    w_if_pc_d      = r_if_pc;
    w_if_instr_d   = r_if_instr;

    // Decode takes the IF/ID instruction whenever it is not stalled; leave a
    // bubble unless a new instruction is loaded below.
    if (!stall_i) w_if_valid_d = 1'b0;

    unique case (r_state)
      StIdle: w_state_d = StReq;
      StReq: begin
        w_state_d = StWait;
        // The request has already gone out; its response must be discarded.
        if (redirect_i) w_drop_d = 1'b1;
      end
      StWait: begin
        if (imem.rvalid) begin
          if (r_drop || redirect_i) begin
            w_drop_d  = 1'b0;
            w_state_d = StReq;
          end else if (!r_if_valid || !stall_i) begin
            w_if_valid_d = 1'b1;
            w_if_pc_d    = r_pc;
            w_if_instr_d = imem.rdata;
            w_pc_d       = next_pc_i;
            w_state_d    = StReq;
          end else begin
            w_skid_pc_d    = r_pc;
            w_skid_instr_d = imem.rdata;
            w_state_d      = StHold;
          end
        end else if (redirect_i) begin
          w_drop_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect_i) begin
          w_state_d = StReq;
        end else if (!stall_i) begin
          w_if_valid_d = 1'b1;
          w_if_pc_d    = r_skid_pc;
          w_if_instr_d = r_skid_instr;
          w_pc_d       = next_pc_i;
          w_state_d    = StReq;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Redirect overrides both stall and accept.
    if (redirect_i) begin
      w_pc_d         = next_pc_i;
      w_if_valid_d   = 1'b0;
      w_skid_pc_d    = '0;
      w_skid_instr_d = '0;
    end
  end

  assign imem.req   = (r_state == StReq);
  // Low PC bits are kept as given but never reach memory.
  assign imem.addr  = {r_pc[NB-1:2], 2'b00};
  assign pc_o       = r_pc;
  assign if_valid_o = r_if_valid;
  assign if_pc_o    = r_if_pc;
  assign if_instr_o = r_if_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a random
// phase where a scoreboard of the expected in-order instruction stream is
// compared against every instruction decode consumes.
module tb_fetch_unit;
  localparam int unsigned NB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   next_pc;
  logic          redirect = 1'b0;
  logic          stall = 1'b0;
  logic [31:0]   tgt = 32'h0;
  logic [31:0]   pc_o;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;

  fetch_imem_if #(.NB(NB)) imem_bus ();

  fetch_unit #(.NB(NB), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc_i  (next_pc),
    .redirect_i (redirect),
    .stall_i    (stall),
    .pc_o       (pc_o),
    .imem       (imem_bus),
    .if_valid_o (if_valid),
    .if_pc_o    (if_pc),
    .if_instr_o (if_instr)
  );

  always #5 clk = ~clk;

  // Next-PC mux: sequential fetch unless redirecting.
  assign next_pc = redirect ? tgt : pc_o + 32'd4;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program image: word at the aligned address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_000C) return 32'h00A0_0093;
    return (w * 32'h9E37_79B1) ^ 32'h0013_0013;
  endfunction

  // Memory model: latency lat_fixed, or random 1..3 when lat_fixed is 0.
  int          lat_fixed = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  initial begin
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_bus.rvalid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = mem_word(mem_addr);
          mem_busy        = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      @(negedge clk);
      if (rst_n && imem_bus.req) begin
        check("req_addr_aligned", {30'b0, imem_bus.addr[1:0]}, 32'h0);
        check("single_outstanding", {31'b0, mem_busy}, 32'h0);
        mem_busy = 1'b1;
        mem_cnt  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
        mem_addr = imem_bus.addr;
      end
    end
  end

  // Scoreboard of the expected consumed stream.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tail_pc = 32'h0;
  bit          mon_en = 1'b0;

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    tail_pc = start;
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: tail_pc, instr: mem_word(tail_pc)});
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        check("stream_nonempty", 32'h0, 32'h1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("stream_pc", if_pc, e.pc);
        check("stream_instr", if_instr, e.instr);
        consumed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_pc", pc_o, 32'h0);
    check("rst_req", 32'(imem_bus.req), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single-cycle memory, no stall: sequential fetch every 2 cycles
    tick();
    check("t1_req0", 32'(imem_bus.req), 32'h1);
    check("t1_addr0", imem_bus.addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      check("t1_if_valid", 32'(if_valid), 32'h1);
      check("t1_if_pc", if_pc, 32'(4 * k));
      check("t1_if_instr", if_instr, mem_word(32'(4 * k)));
      check("t1_next_addr", imem_bus.addr, 32'(4 * (k + 1)));
    end

    // Stall with a valid IF/ID: response goes to the skid buffer
    stall = 1'b1;
    tick();
    tick();
    check("t2_hold_noreq", 32'(imem_bus.req), 32'h0);
    check("t2_hold_valid", 32'(if_valid), 32'h1);
    check("t2_hold_pc", if_pc, 32'h8);
    tick();
    check("t2_hold_noreq2", 32'(imem_bus.req), 32'h0);
    stall = 1'b0;
    tick();
    check("t2_skid_valid", 32'(if_valid), 32'h1);
    check("t2_skid_pc", if_pc, 32'hC);
    check("t2_skid_instr", if_instr, 32'h00A0_0093);
    check("t2_req_resume", 32'(imem_bus.req), 32'h1);
    check("t2_addr_resume", imem_bus.addr, 32'h10);

    // Redirect during WAIT, stale response arrives later
    lat_fixed = 3;
    tick();
    redirect = 1'b1;
    tgt = 32'h100;
    tick();
    redirect = 1'b0;
    lat_fixed = 1;
    check("t3_pc", pc_o, 32'h100);
    check("t3_flush", 32'(if_valid), 32'h0);
    check("t3_noreq", 32'(imem_bus.req), 32'h0);
    tick();
    check("t3_wait_noreq", 32'(imem_bus.req), 32'h0);
    tick();
    check("t3_drop_valid", 32'(if_valid), 32'h0);
    check("t3_req", 32'(imem_bus.req), 32'h1);
    check("t3_addr", imem_bus.addr, 32'h100);

    // Redirect together with stall while in HOLD
    tick();
    tick();
    check("t4_if_pc", if_pc, 32'h100);
    stall = 1'b1;
    tick();
    tick();
    check("t4_hold_noreq", 32'(imem_bus.req), 32'h0);
    check("t4_hold_valid", 32'(if_valid), 32'h1);
    redirect = 1'b1;
    tgt = 32'h200;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    check("t4_flush", 32'(if_valid), 32'h0);
    check("t4_req", 32'(imem_bus.req), 32'h1);
    check("t4_addr", imem_bus.addr, 32'h200);

    // Misaligned target: address bits [1:0] forced to 0, PC kept as given
    tick();
    tick();
    check("t6_prev_pc", if_pc, 32'h200);
    redirect = 1'b1;
    tgt = 32'h102;
    tick();
    redirect = 1'b0;
    check("t6_pc", pc_o, 32'h102);
    tick();
    check("t6_req", 32'(imem_bus.req), 32'h1);
    check("t6_addr", imem_bus.addr, 32'h100);
    tick();
    tick();
    check("t6_if_valid", 32'(if_valid), 32'h1);
    check("t6_if_pc", if_pc, 32'h102);
    check("t6_if_instr", if_instr, mem_word(32'h100));
    check("t6_next_addr", imem_bus.addr, 32'h104);
    lat_fixed = 2;

    // Reset in the middle of WAIT; response arrives during and just after reset
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_pc", pc_o, 32'h0);
    check("t5_rst_req", 32'(imem_bus.req), 32'h0);
    check("t5_rst_valid", 32'(if_valid), 32'h0);
    check("t5_rst_if_pc", if_pc, 32'h0);
    check("t5_rst_if_instr", if_instr, 32'h0);
    tick();
    check("t5_rst_hold_valid", 32'(if_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    check("t5_req", 32'(imem_bus.req), 32'h1);
    check("t5_addr", imem_bus.addr, 32'h0);
    check("t5_valid", 32'(if_valid), 32'h0);

    // Random phase
    lat_fixed = 0;
    restart_stream(32'h0);
    top_up();
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (redirect) restart_stream(tgt);
      #2;
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      if (redirect) tgt = 32'($urandom_range(0, 4095));
      top_up();
    end
    @(posedge clk);
    #2;
    redirect = 1'b0;
    mon_en = 1'b0;
    check("progress", 32'(consumed > 100), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
